stage3_ex: RTL and testbench
============================

Name: stage3_ex

Overview:
- Execute stage of the 5-stage pipeline, directly upstream of the memory stage.
- Selects operand B as either the register value or the immediate, and computes the ALU result.
- Runs multi-cycle multiply/divide through an iterative unit that stalls the upstream stages.
- Registers the result, store data, destination address and control bits into the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- WIDTH, 32, datapath width. The shift-amount field and the iteration count both derive from it.
- ADDR_W, 6, width of the register write address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstb  in  1  reset, asynchronous, active-low.
- valid_in  in  1  an instruction is present on the inputs.
- flush  in  1  kill the in-flight and presented instruction.
- regA_rd_data_in  in  WIDTH  operand A.
- regB_rd_data_in  in  WIDTH  operand B; also the store data.
- imm_in  in  WIDTH  sign-extended immediate.
- alu_src_imm  in  1  1 = operand B is imm_in.
- alu_op  in  4  operation code.
- reg_wr_addr_in  in  ADDR_W  destination register.
- reg_wr_en_in, mem_wr_en_in, mem_rd_en_in  in  1 each  control bits carried forward.
- stall_out  out  1  upstream stages must hold all inputs stable.
- valid_out  out  1  EX/MEM register holds a real instruction.
- alu_result_out  out  WIDTH  result; used as the memory address.
- regB_rd_data_out  out  WIDTH  store data.
- reg_wr_addr_out  out  ADDR_W  destination register.
- reg_wr_en_out, mem_wr_en_out, mem_rd_en_out  out  1 each  registered control bits.

Behaviour:
- Reset: every registered output clears to 0 asynchronously while rstb=0. The FSM goes to IDLE and the iteration counter clears to 0. Reset during an iteration abandons it.
- alu_op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed), 7 SLTU. Both return 1 or 0, zero-extended.
  - 8 SLL, 9 SRL, 10 SRA. Shift amount = B[4:0].
  - 11 LUI: result = B<<16.
  - 12 MUL: low WIDTH bits of the product.
  - 13 DIVU: unsigned quotient. 14 REMU: unsigned remainder.
  - 15: result 0.
- Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- Single-cycle ops, with valid_in=1 and the FSM in IDLE:
  - Result and carried fields load into the EX/MEM register on the next edge.
  - Latency is 1 cycle; stall_out stays 0.
- Bubble rule: whenever the EX/MEM register loads a bubble, valid_out, reg_wr_en_out, mem_wr_en_out and mem_rd_en_out go to 0. Data fields are don't-care; the implementation holds their previous value.
- Idle input: valid_in=0 loads a bubble.
- FSM states IDLE, BUSY, DONE, for ops 12–14:
  - IDLE with valid_in and a muldiv op: stall_out=1 combinationally. Next edge latches the operands, sets cnt=0, goes to BUSY and loads a bubble.
  - BUSY: stall_out=1. One shift-add or restoring-subtract step per cycle; cnt increments. The edge with cnt=WIDTH-1 goes to DONE. A bubble loads every cycle.
  - DONE: stall_out=0. The next edge loads the result plus the held inputs' control into EX/MEM and returns to IDLE.
  - Total: stall_out is high for WIDTH+1 cycles; the result is valid in cycle WIDTH+2 counted from presentation (cycle 0).
- Divide by zero keeps the full latency. DIVU returns all-ones; REMU returns the dividend.
- flush has highest priority:
  - In any state: the next edge returns to IDLE and loads a bubble.
  - stall_out is 0 in the cycle flush is high.
  - A flush in DONE discards the result.
- Upstream contract: inputs must not change while stall_out=1. The block re-samples the control bits from the inputs in DONE.

Optional Feature:
- Macro: STAGE3_EX_MULDIV_EN.
- Defined: iterative unit and FSM present, as above.
- Undefined:
  - No FSM and no iteration unit.
  - stall_out is tied to 0.
  - Ops 12–14 behave like op 15: result 0, 1-cycle latency, control bits carried normally.

Decomposition:
- Shared package stage3_ex_pkg holds:
  - alu_op code constants (ALU_ADD … ALU_REMU).
  - FSM state encoding (IDLE, BUSY, DONE).
  - Constant MULDIV_CYCLES = WIDTH.
- One sub-module muldiv_iter. It owns the operand and partial registers, the counter and the done pulse. Inputs: start, op select, a, b, flush. Outputs: busy, done, result.
- stage3_ex holds the combinational ALU, the operand mux, the top FSM and the EX/MEM register.

Test Plan:
- Reset: hold rstb=0 mid-BUSY, release -> all outputs 0, stall_out=0, FSM IDLE; a following ADD 3+4 gives alu_result_out=7 one edge later.
- ALU sweep: A=0xFFFFFFF0, B=0x10 -> ADD=0, SLT=1, SLTU=0, SRA by 4=0xFFFFFFFF.
- Immediate and pass-through: alu_src_imm=1, imm=0x12, SLL -> B[4:0]=18 shift. mem_wr_en and reg_wr_addr=5 propagate after 1 cycle with valid_out=1.
- MUL 0x10000×0x10001 -> 0x00010000. stall_out high exactly 33 cycles; 33 bubbles emitted, then the result with valid_out=1.
- DIVU 100/7=14, REMU=2. DIVU x/0 -> 0xFFFFFFFF; REMU 9/0 -> 9.
- flush at BUSY cnt=10 -> next edge IDLE, bubble, stall_out low. Back-to-back ADD accepted on the following cycle. With the macro undefined, MUL -> 0 with no stall.

Source files
------------

// File: rtl/stage3_ex_pkg.sv
// stage3_ex_pkg: opcode, FSM state and iteration constants shared by the execute stage
package stage3_ex_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;
  localparam logic [3:0] ALU_DIVU = 4'd13;
  localparam logic [3:0] ALU_REMU = 4'd14;
  localparam logic [3:0] ALU_ZERO = 4'd15;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int WIDTH_DEF = 32;
  localparam int MULDIV_CYCLES = WIDTH_DEF;
  typedef struct packed {
    logic reg_wr_en;
    logic mem_wr_en;
    logic mem_rd_en;
  } ctrl_t;
  function automatic logic is_muldiv(input logic [3:0] op);
    return op == ALU_MUL || op == ALU_DIVU || op == ALU_REMU;
  endfunction
endpackage

// File: rtl/stage3_ex_if.sv
// stage3_ex_if: decode-side inputs and EX/MEM outputs of the execute stage
interface stage3_ex_if #(parameter int WIDTH = 32, parameter int ADDR_W = 6);
  logic              valid_in;
  logic              flush;
  logic [WIDTH-1:0]  regA_rd_data_in;
  logic [WIDTH-1:0]  regB_rd_data_in;
  logic [WIDTH-1:0]  imm_in;
  logic              alu_src_imm;
  logic [3:0]        alu_op;
  logic [ADDR_W-1:0] reg_wr_addr_in;
  logic              reg_wr_en_in;
  logic              mem_wr_en_in;
  logic              mem_rd_en_in;
  logic              stall_out;
  logic              valid_out;
  logic [WIDTH-1:0]  alu_result_out;
  logic [WIDTH-1:0]  regB_rd_data_out;
  logic [ADDR_W-1:0] reg_wr_addr_out;
  logic              reg_wr_en_out;
  logic              mem_wr_en_out;
  logic              mem_rd_en_out;
  modport master (
    output valid_in, flush, regA_rd_data_in, regB_rd_data_in, imm_in, alu_src_imm, alu_op,
           reg_wr_addr_in, reg_wr_en_in, mem_wr_en_in, mem_rd_en_in,
    input  stall_out, valid_out, alu_result_out, regB_rd_data_out, reg_wr_addr_out,
           reg_wr_en_out, mem_wr_en_out, mem_rd_en_out
  );
  modport slave (
    input  valid_in, flush, regA_rd_data_in, regB_rd_data_in, imm_in, alu_src_imm, alu_op,
           reg_wr_addr_in, reg_wr_en_in, mem_wr_en_in, mem_rd_en_in,
    output stall_out, valid_out, alu_result_out, regB_rd_data_out, reg_wr_addr_out,
           reg_wr_en_out, mem_wr_en_out, mem_rd_en_out
  );
endinterface

// File: rtl/stage3_ex_muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle shift-add multiplier and restoring divider
module muldiv_iter
  import stage3_ex_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int CYCLES = MULDIV_CYCLES
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(CYCLES);
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p, q, d;
  logic [WIDTH:0]   shl, sub;
  logic             mul, quo;
  // p is the product accumulator or the partial remainder; q the multiplier or the quotient
  assign shl    = {p, q[WIDTH-1]};
  assign sub    = shl - {1'b0, d};
  assign done   = busy && cnt == CW'(CYCLES - 1);
  assign result = quo ? q : p;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      busy <= 1'b0;
      cnt  <= '0;
      p    <= '0;
      q    <= '0;
      d    <= '0;
      mul  <= 1'b0;
      quo  <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      p    <= '0;
      mul  <= op == 2'd0;
      quo  <= op == 2'd1;
      q    <= op == 2'd0 ? b : a;
      d    <= op == 2'd0 ? a : b;
    end else if (busy) begin
      busy <= !done;
      cnt  <= cnt + 1'b1;
      if (mul) begin
        p <= p + (q[0] ? d : '0);
        q <= q >> 1;
        d <= d << 1;
      end else begin
        p <= sub[WIDTH] ? shl[WIDTH-1:0] : sub[WIDTH-1:0];
        q <= {q[WIDTH-2:0], ~sub[WIDTH]};
      end
    end
endmodule

// File: rtl/stage3_ex.sv
// stage3_ex: execute stage with ALU, operand mux and EX/MEM register.
// STAGE3_EX_MULDIV_EN adds the stalling iterative multiply/divide unit.
module stage3_ex
  import stage3_ex_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = 6
) (
  input logic        clk,
  input logic        rstb,
  stage3_ex_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  logic [WIDTH-1:0] a, b, alu, res;
  logic [SHW-1:0]   sh;
  logic             load;
  ctrl_t            ctrl;
  assign a    = bus.regA_rd_data_in;
  assign b    = bus.alu_src_imm ? bus.imm_in : bus.regB_rd_data_in;
  assign sh   = b[SHW-1:0];
  assign ctrl = '{bus.reg_wr_en_in, bus.mem_wr_en_in, bus.mem_rd_en_in};
  always_comb begin
    alu = '0;
    case (bus.alu_op)
      ALU_ADD:  alu = a + b;
      ALU_SUB:  alu = a - b;
      ALU_AND:  alu = a & b;
      ALU_OR:   alu = a | b;
      ALU_XOR:  alu = a ^ b;
      ALU_NOR:  alu = ~(a | b);
      ALU_SLT:  alu = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: alu = {{(WIDTH-1){1'b0}}, a < b};
      ALU_SLL:  alu = a << sh;
      ALU_SRL:  alu = a >> sh;
      ALU_SRA:  alu = $signed(a) >>> sh;
      ALU_LUI:  alu = b << 16;
      default:  alu = '0;
    endcase
  end
`ifdef STAGE3_EX_MULDIV_EN
  logic [1:0]       state;
  logic             start, md_busy, md_done;
  logic [WIDTH-1:0] md_res;
  assign start         = state == IDLE && bus.valid_in && is_muldiv(bus.alu_op) && !bus.flush;
  assign bus.stall_out = !bus.flush && (start || state == BUSY);
  assign load          = !bus.flush && (state == DONE ||
                         (state == IDLE && bus.valid_in && !is_muldiv(bus.alu_op)));
  assign res           = state == DONE ? md_res : alu;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) state <= IDLE;
    else if (bus.flush) state <= IDLE;
    else state <= start ? BUSY :
                  state == BUSY ? (md_done ? DONE : md_busy ? BUSY : IDLE) : IDLE;
  muldiv_iter #(.WIDTH(WIDTH), .CYCLES(WIDTH)) u_muldiv (
    .clk    (clk),
    .rstb   (rstb),
    .start  (start),
    .flush  (bus.flush),
    .op     (bus.alu_op[1:0]),
    .a      (a),
    .b      (b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_res)
  );
`else
  assign bus.stall_out = 1'b0;
  assign load          = bus.valid_in && !bus.flush;
  assign res           = alu;
`endif
  // bubbles clear valid and control only; data fields keep their last value
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      bus.valid_out        <= 1'b0;
      bus.reg_wr_en_out    <= 1'b0;
      bus.mem_wr_en_out    <= 1'b0;
      bus.mem_rd_en_out    <= 1'b0;
      bus.alu_result_out   <= '0;
      bus.regB_rd_data_out <= '0;
      bus.reg_wr_addr_out  <= '0;
    end else begin
      bus.valid_out <= load;
      {bus.reg_wr_en_out, bus.mem_wr_en_out, bus.mem_rd_en_out} <= load ? ctrl : '0;
      if (load) begin
        bus.alu_result_out   <= res;
        bus.regB_rd_data_out <= bus.regB_rd_data_in;
        bus.reg_wr_addr_out  <= bus.reg_wr_addr_in;
      end
    end
endmodule

// File: tb/tb_stage3_ex.sv
// tb_stage3_ex: directed checks of the execute stage; muldiv checks when STAGE3_EX_MULDIV_EN is set
module tb_stage3_ex;
  import stage3_ex_pkg::*;
  logic clk = 1'b0;
  logic rstb = 1'b0;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  stage3_ex_if #(.WIDTH(32), .ADDR_W(6)) bus ();
  stage3_ex #(.WIDTH(32), .ADDR_W(6)) dut (.clk(clk), .rstb(rstb), .bus(bus));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.valid_in        = 1'b1;
    bus.alu_op          = op;
    bus.regA_rd_data_in = a;
    bus.regB_rd_data_in = b;
    bus.alu_src_imm     = 1'b0;
  endtask
`ifdef STAGE3_EX_MULDIV_EN
  task automatic run_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n = 0;
    int bub = 0;
    drive(op, a, b);
    while (bus.stall_out === 1'b1 && n < 100) begin
      tick();
      n++;
      if (bus.valid_out === 1'b0) bub++;
    end
    chk({tag, "_stall_cycles"}, n, 33);
    chk({tag, "_bubbles"}, bub, 33);
    tick();
    chk(tag, bus.alu_result_out, exp);
    chk({tag, "_valid"}, bus.valid_out, 1);
    bus.valid_in = 1'b0;
  endtask
`endif
  initial begin
    bus.valid_in = 0; bus.flush = 0; bus.regA_rd_data_in = 0; bus.regB_rd_data_in = 0;
    bus.imm_in = 0; bus.alu_src_imm = 0; bus.alu_op = 0; bus.reg_wr_addr_in = 0;
    bus.reg_wr_en_in = 0; bus.mem_wr_en_in = 0; bus.mem_rd_en_in = 0;
    drive(ALU_ADD, 3, 4);
    bus.reg_wr_en_in = 1'b1;
    repeat (2) tick();
    chk("rst_valid", bus.valid_out, 0);
    chk("rst_result", bus.alu_result_out, 0);
    chk("rst_stall", bus.stall_out, 0);
    chk("rst_ctrl", {bus.reg_wr_en_out, bus.mem_wr_en_out, bus.mem_rd_en_out}, 0);
    rstb = 1'b1;
    tick();
    chk("add_3_4", bus.alu_result_out, 7);
    chk("add_valid", bus.valid_out, 1);
    chk("add_reg_wr_en", bus.reg_wr_en_out, 1);
    drive(ALU_ADD, 32'hFFFF_FFF0, 32'h10);  tick(); chk("sweep_add", bus.alu_result_out, 32'h0);
    drive(ALU_SUB, 32'hFFFF_FFF0, 32'h10);  tick(); chk("sweep_sub", bus.alu_result_out, 32'hFFFF_FFE0);
    drive(ALU_AND, 32'hFFFF_FFF0, 32'h10);  tick(); chk("sweep_and", bus.alu_result_out, 32'h10);
    drive(ALU_OR, 32'hFFFF_FFF0, 32'h10);   tick(); chk("sweep_or", bus.alu_result_out, 32'hFFFF_FFF0);
    drive(ALU_XOR, 32'hFFFF_FFF0, 32'h10);  tick(); chk("sweep_xor", bus.alu_result_out, 32'hFFFF_FFE0);
    drive(ALU_NOR, 32'hFFFF_FFF0, 32'h10);  tick(); chk("sweep_nor", bus.alu_result_out, 32'hF);
    drive(ALU_SLT, 32'hFFFF_FFF0, 32'h10);  tick(); chk("sweep_slt", bus.alu_result_out, 32'h1);
    drive(ALU_SLTU, 32'hFFFF_FFF0, 32'h10); tick(); chk("sweep_sltu", bus.alu_result_out, 32'h0);
    drive(ALU_SRA, 32'hFFFF_FFF0, 32'h4);   tick(); chk("sweep_sra", bus.alu_result_out, 32'hFFFF_FFFF);
    drive(ALU_SRL, 32'hFFFF_FFF0, 32'h4);   tick(); chk("sweep_srl", bus.alu_result_out, 32'h0FFF_FFFF);
    drive(ALU_LUI, 32'h0, 32'h1234);        tick(); chk("sweep_lui", bus.alu_result_out, 32'h1234_0000);
    drive(ALU_SLL, 32'h1, 32'hFFFF);
    bus.alu_src_imm = 1'b1; bus.imm_in = 32'h12; bus.reg_wr_addr_in = 6'd5;
    bus.mem_wr_en_in = 1'b1; bus.reg_wr_en_in = 1'b0;
    tick();
    chk("imm_sll", bus.alu_result_out, 32'h0004_0000);
    chk("store_data", bus.regB_rd_data_out, 32'hFFFF);
    chk("wr_addr", bus.reg_wr_addr_out, 5);
    chk("mem_wr_en", bus.mem_wr_en_out, 1);
    chk("imm_reg_wr_en", bus.reg_wr_en_out, 0);
    chk("imm_valid", bus.valid_out, 1);
    bus.valid_in = 1'b0;
    tick();
    chk("idle_valid", bus.valid_out, 0);
    chk("idle_mem_wr_en", bus.mem_wr_en_out, 0);
    chk("idle_hold", bus.alu_result_out, 32'h0004_0000);
    drive(ALU_ADD, 1, 1);
    bus.flush = 1'b1;
    #1 chk("flush_stall", bus.stall_out, 0);
    tick();
    chk("flush_valid", bus.valid_out, 0);
    chk("flush_mem_wr_en", bus.mem_wr_en_out, 0);
    bus.flush = 1'b0; bus.mem_wr_en_in = 1'b0; bus.reg_wr_en_in = 1'b1;
    drive(ALU_ZERO, 5, 6); tick();
    chk("op15_zero", bus.alu_result_out, 0);
    chk("op15_reg_wr_en", bus.reg_wr_en_out, 1);
`ifdef STAGE3_EX_MULDIV_EN
    run_md("mul", ALU_MUL, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000);
    run_md("divu", ALU_DIVU, 100, 7, 14);
    run_md("remu", ALU_REMU, 100, 7, 2);
    run_md("divu_by0", ALU_DIVU, 32'h1234_5678, 0, 32'hFFFF_FFFF);
    run_md("remu_by0", ALU_REMU, 9, 0, 9);
    drive(ALU_DIVU, 100, 7);
    repeat (11) tick();
    chk("busy_stall", bus.stall_out, 1);
    bus.flush = 1'b1;
    #1 chk("busy_flush_stall", bus.stall_out, 0);
    tick();
    bus.flush = 1'b0;
    drive(ALU_ADD, 1, 2);
    #1 chk("post_flush_stall", bus.stall_out, 0);
    chk("post_flush_bubble", bus.valid_out, 0);
    tick();
    chk("post_flush_add", bus.alu_result_out, 3);
    chk("post_flush_valid", bus.valid_out, 1);
`else
    drive(ALU_MUL, 32'h0001_0000, 32'h0001_0001);
    #1 chk("nomd_mul_stall", bus.stall_out, 0);
    tick();
    chk("nomd_mul", bus.alu_result_out, 0);
    chk("nomd_mul_valid", bus.valid_out, 1);
    drive(ALU_DIVU, 100, 7); tick();
    chk("nomd_divu", bus.alu_result_out, 0);
`endif
    drive(ALU_MUL, 5, 6);
    repeat (5) tick();
    rstb = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    chk("midrst_valid", bus.valid_out, 0);
    chk("midrst_result", bus.alu_result_out, 0);
    chk("midrst_stall", bus.stall_out, 0);
    tick();
    rstb = 1'b1;
    drive(ALU_ADD, 3, 4);
    #1 chk("midrst_idle_stall", bus.stall_out, 0);
    tick();
    chk("midrst_add", bus.alu_result_out, 7);
    chk("midrst_add_valid", bus.valid_out, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
